// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC width, special instruction words, fetch FSM
// encoding and the MEM/WB jump_type codes.
package cpu_pkg;

  localparam int          PC_W       = 5;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } if_state_e;

  localparam logic [2:0] JT_BEQ = 3'b100;
  localparam logic [2:0] JT_BNE = 3'b110;
  localparam logic [2:0] JT_JAL = 3'b001;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble (or reset) beats load, load beats hold.
module if_id_reg #(
  parameter int PC_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            bubble,
  input  logic [PC_W-1:0] in_pc,
  input  logic [PC_W-1:0] in_pc_plus1,
  input  logic [31:0]     in_instr,
  output logic [PC_W-1:0] id_pc,
  output logic [PC_W-1:0] id_pc_plus1,
  output logic [31:0]     id_instr,
  output logic            id_valid
);
  import cpu_pkg::*;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] pc_q, pc_d, pc1_q, pc1_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;

  // A bubble keeps pc_plus1 consistent with its zero PC.
  always_comb begin
    pc_d    = pc_q;
    pc1_d   = pc1_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (bubble) begin
      pc_d    = '0;
      pc1_d   = PC_ONE;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      pc_d    = in_pc;
      pc1_d   = in_pc_plus1;
      instr_d = in_instr;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= '0;
      pc1_q   <= PC_ONE;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pc1_q   <= pc1_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign id_pc       = pc_q;
  assign id_pc_plus1 = pc1_q;
  assign id_instr    = instr_q;
  assign id_valid    = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC/FSM, ROM addressing, redirect and IF/ID register.
// Optional halt-on-all-ones detection is enabled with IF_HALT_DETECT_EN.
module if_stage #(
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             should_jump,
  input  logic [PC_W-1:0]  jump_target,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [PC_W-1:0]  id_pc,
  output logic [PC_W-1:0]  id_pc_plus1,
  output logic [31:0]      id_instr,
  output logic             id_valid,
  output logic             kill_younger,
  output logic [CNT_W-1:0] fetch_count,
  output logic             halted
);
  import cpu_pkg::*;

  if_state_e        state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d, pc_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ifid_load, ifid_bubble;

  assign pc_inc       = pc_q + 1'b1;
  assign kill_younger = should_jump;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    imem_addr   = pc_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    case (state_q)
      ST_BOOT: begin
        ifid_bubble = 1'b1;
        state_d     = ST_RUN;
        if (should_jump) begin
          imem_addr = jump_target;
          pc_d      = jump_target;
        end
      end
      ST_RUN: begin
        if (should_jump) begin
          imem_addr   = jump_target;
          pc_d        = jump_target;
          ifid_bubble = 1'b1;
        end else if (!stall) begin
          imem_addr = pc_inc;
          pc_d      = pc_inc;
          ifid_load = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`ifdef IF_HALT_DETECT_EN
          if (imem_rdata == HALT_INSTR) state_d = ST_HALT;
`endif
        end
      end
`ifdef IF_HALT_DETECT_EN
      ST_HALT: begin
        ifid_bubble = 1'b1;
        if (should_jump) begin
          imem_addr = jump_target;
          pc_d      = jump_target;
          state_d   = ST_RUN;
        end
      end
`endif
      default: begin
        ifid_bubble = 1'b1;
        state_d     = ST_BOOT;
      end
    endcase
    // The ROM must capture RESET_PC while reset is held so BOOT sees it.
    if (!rst_n) imem_addr = RESET_PC;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fetch_count = cnt_q;

`ifdef IF_HALT_DETECT_EN
  assign halted = (state_q == ST_HALT);
`else
  assign halted = 1'b0;
`endif

  if_id_reg #(.PC_W(PC_W)) u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (ifid_load),
    .bubble      (ifid_bubble),
    .in_pc       (pc_q),
    .in_pc_plus1 (pc_inc),
    .in_instr    (imem_rdata),
    .id_pc       (id_pc),
    .id_pc_plus1 (id_pc_plus1),
    .id_instr    (id_instr),
    .id_valid    (id_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed phases then random stall/jump/reset traffic,
// compared each cycle against a cycle-level behavioural model of the fetch rules.
module tb_if_stage;
  localparam int PC_W  = 5;
  localparam int CNT_W = 4;
  localparam int DEPTH = 1 << PC_W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stall = 1'b0;
  logic             should_jump = 1'b0;
  logic [PC_W-1:0]  jump_target = '0;
  logic [PC_W-1:0]  imem_addr;
  logic [31:0]      imem_rdata;
  logic [PC_W-1:0]  id_pc;
  logic [PC_W-1:0]  id_pc_plus1;
  logic [31:0]      id_instr;
  logic             id_valid;
  logic             kill_younger;
  logic [CNT_W-1:0] fetch_count;
  logic             halted;

  logic [31:0] rom [DEPTH];

  if_stage #(.PC_W(PC_W), .RESET_PC('0), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .should_jump  (should_jump),
    .jump_target  (jump_target),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .id_pc        (id_pc),
    .id_pc_plus1  (id_pc_plus1),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .kill_younger (kill_younger),
    .fetch_count  (fetch_count),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= rom[imem_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model: m_pc is the address whose instruction arrives this cycle.
  bit          m_live = 0;
  bit          m_boot = 1;
  bit          m_halt = 0;
  int          m_pc   = 0;
  int          m_cnt  = 0;
  bit          e_valid = 0;
  int          e_pc    = 0;
  logic [31:0] e_instr = '0;

  task automatic step(input bit r, input bit s, input bit j, input int t);
    int exp_addr;
    @(negedge clk);
    rst_n       = r;
    stall       = s;
    should_jump = j;
    jump_target = t[PC_W-1:0];
    #1;
    if (!r)          exp_addr = 0;
    else if (j)      exp_addr = t;
    else if (m_boot || m_halt || s) exp_addr = m_pc;
    else             exp_addr = (m_pc + 1) % DEPTH;
    check("kill_younger", 32'(kill_younger), 32'(j));
    if (m_live || !r) check("imem_addr", 32'(imem_addr), exp_addr);
    if (m_live) begin
      check("id_valid", 32'(id_valid), 32'(e_valid));
      check("id_pc", 32'(id_pc), e_pc);
      check("id_instr", id_instr, e_instr);
      if (e_valid) check("id_pc_plus1", 32'(id_pc_plus1), (e_pc + 1) % DEPTH);
      check("fetch_count", 32'(fetch_count), m_cnt);
      check("halted", 32'(halted), 32'(m_halt));
    end
    @(posedge clk);
    if (!r) begin
      m_live = 1; m_boot = 1; m_halt = 0; m_pc = 0; m_cnt = 0;
      e_valid = 0; e_pc = 0; e_instr = '0;
    end else if (m_boot) begin
      m_boot = 0;
      e_valid = 0; e_pc = 0; e_instr = '0;
      if (j) m_pc = t;
    end else if (j) begin
      m_halt = 0; m_pc = t;
      e_valid = 0; e_pc = 0; e_instr = '0;
    end else if (m_halt) begin
      e_valid = 0; e_pc = 0; e_instr = '0;
    end else if (!s) begin
      e_valid = 1; e_pc = m_pc; e_instr = rom[m_pc];
      m_cnt   = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
`ifdef IF_HALT_DETECT_EN
      if (rom[m_pc] == 32'hFFFF_FFFF) m_halt = 1;
`endif
      m_pc = (m_pc + 1) % DEPTH;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'(i + 100);
`ifdef IF_HALT_DETECT_EN
    rom[3] = 32'hFFFF_FFFF;
`endif
    step(0, 0, 0, 0);
    step(0, 0, 1, 9);
    for (int i = 0; i < 40; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 2);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 1, 20);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(0, 0, 1, 7);
    step(1, 1, 1, 25);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 8);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      bit r, s, j;
      int t;
      r = ($urandom_range(0, 39) != 0);
      s = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 7) == 0);
      t = int'($urandom_range(0, DEPTH - 1));
      step(r, s, j, t);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register at the front of the 5-bit-PC pipelined CPU.
- Owns the PC and drives the address of the synchronous instruction ROM (1-cycle read latency).
- Presents fetched instructions to decode.
- Consumes the MEM/WB stage's should_jump plus the resolved target, redirects fetch, and kills wrong-path younger instructions.

Parameters:
PC_W, 5, PC/instruction-address width (word addressed)
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, width of the saturating fetch counter

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
stall  in  1  decode hazard; IF/ID must hold its contents
should_jump  in  1  taken jump/branch resolved in MEM/WB stage
jump_target  in  PC_W  redirect address, valid when should_jump=1
imem_addr  out  PC_W  address to instruction ROM (ROM registers it internally)
imem_rdata  in  32  ROM data for the address registered last cycle
id_pc  out  PC_W  PC of the instruction in IF/ID
id_pc_plus1  out  PC_W  id_pc+1 mod 2^PC_W (link value for jal/jalr)
id_instr  out  32  instruction in IF/ID
id_valid  out  1  IF/ID holds a real instruction
kill_younger  out  1  flush ID/EX and EX/MEM this cycle
fetch_count  out  CNT_W  instructions accepted into IF/ID, saturating
halted  out  1  fetch halted (0 unless optional feature compiled in)

Behaviour:
- Internal pc_q is the address whose data imem_rdata returns this cycle.
- FSM states: BOOT, RUN (plus HALT with the feature).
- Reset (rst_n=0 at edge):
  - pc_q=RESET_PC; state=BOOT.
  - IF/ID = bubble: id_pc=0, id_instr=0 (NOP), id_valid=0.
  - fetch_count=0; halted=0.
  - While rst_n=0, imem_addr=RESET_PC.
  - Reset mid-operation discards all in-flight state.
- kill_younger = should_jump, combinational, in every state.
- BOOT (one cycle; imem_rdata not yet valid):
  - imem_addr=pc_q; IF/ID loads bubble; next state RUN.
  - If should_jump: imem_addr=jump_target and pc_q<=jump_target.
  - stall is ignored in BOOT.
- RUN, priority jump > stall > advance:
  - should_jump: imem_addr=jump_target; pc_q<=jump_target; IF/ID loads bubble (the instruction at pc_q is wrong-path). This applies even when stall=1.
  - stall: imem_addr=pc_q (ROM re-reads); pc_q holds; IF/ID holds; fetch_count holds.
  - advance: imem_addr=pc_q+1; pc_q<=pc_q+1; IF/ID <= {pc_q, pc_q+1, imem_rdata, valid=1}; fetch_count++.
- Arithmetic:
  - PC increments wrap modulo 2^PC_W (31 -> 0 at default).
  - fetch_count saturates at all-ones.
- Latency:
  - Address to IF/ID is 2 edges (ROM register, then IF/ID register).
  - Redirect: the target instruction appears in IF/ID 2 edges after the should_jump cycle, with exactly one bubble between.
- Simultaneous should_jump and rst_n=0: reset wins.

Optional Feature:
Macro IF_HALT_DETECT_EN.
- Defined:
  - In RUN, advancing with imem_rdata==32'hFFFF_FFFF loads it into IF/ID normally, then state goes to HALT.
  - HALT: imem_addr=pc_q; pc_q holds; IF/ID loads bubbles; halted=1; fetch_count holds.
  - should_jump in HALT (an older in-flight jump) redirects as in RUN, state goes to RUN, and halted=0 next cycle.
- Undefined: the pattern is an ordinary instruction, HALT does not exist, and halted is tied 0.

Decomposition:
- Shared package cpu_pkg:
  - PC_W, NOP_INSTR (32'h0), HALT_INSTR (32'hFFFF_FFFF).
  - FSM state encoding.
  - jump_type encodings used by the MEM/WB stage: beq 3'b100, bne 3'b110, jal/jalr 3'b001.
- One natural sub-module, if_id_reg: holds id_pc, id_pc_plus1, id_instr, id_valid, with load/hold/bubble controls.
- PC/FSM logic stays in if_stage.

Test Plan:
- Reset, no stall, ROM[i]=i+100 -> imem_addr 0,1,2...; after 2 edges, IF/ID shows id_pc=0, id_instr=100, id_valid=1, then 1/101, 2/102; fetch_count increments per cycle.
- Run to pc_q=31 -> imem_addr wraps to 0; id_pc=31 has id_pc_plus1=0.
- stall=1 for 3 cycles at pc_q=5 -> IF/ID frozen at id_pc=4, imem_addr=5 held, fetch_count unchanged; release -> id_pc=5 next edge.
- should_jump=1, jump_target=20, with stall=1 -> kill_younger=1 that cycle, imem_addr=20, next IF/ID is a bubble, then id_pc=20, id_instr=ROM[20].
- rst_n=0 for one edge mid-run at pc_q=12 -> pc_q=0, id_valid=0, fetch_count=0; BOOT bubble, then fetch resumes from 0.
- (IF_HALT_DETECT_EN) ROM[3]=32'hFFFF_FFFF -> id_pc=3 valid, then halted=1 with bubbles; should_jump to 8 -> halted=0, id_pc=8 two edges later.
